// File: rtl/sop_ctrl_pkg.sv
// Shared types and constants for the SOP sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sop_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Truth table of y = a'b'c' + a'b'c + abc (minterms 0, 1, 7).
  localparam logic [7:0] SOP_EXPECTED_DEFAULT = 8'h83;

  localparam int ERRCNT_W = 8;
  localparam int SETTLE_W = 16;

endpackage

// File: rtl/sop_settle_timer.sv
// Settle timer: loadable down-counter; expire_o flags the last count while enabled.
// Latency: expire_o is combinational from the count; load/clear/decrement take effect next edge.
// Backpressure: none; en_i simply gates counting.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr_i         force count to 0 (lower priority than load_i)
//   load_i        load load_val_i
//   load_val_i    settle cycles minus one
//   en_i          count down while high
//   expire_o      high when enabled and the count has reached 0
module sop_settle_timer
  import sop_ctrl_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Sweeps an external N-input SOP block through all minterms, captures its truth table, checks it.
// Latency: STEP_DIV+1 cycles per vector; done_o on the 2^N*(STEP_DIV+1)+1-th edge counting the start edge.
// Backpressure: none; start_i is ignored while busy, abort_i abandons a sweep from APPLY/SAMPLE.
//
// Optional build macro SOP_SWEEP_ERRCNT_EN: when defined, err_cnt_o counts failed sweeps
// (saturating at 255, cleared only by reset); otherwise err_cnt_o is tied to 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        begin a sweep (sampled in IDLE; abort_i has priority)
//   abort_i        abandon the sweep from APPLY or SAMPLE
//   y_i            output of the SOP datapath under test
//   vec_o          vector driven to the datapath ({a,b,c}, a = MSB); 0 when not busy
//   busy_o         high in APPLY and SAMPLE
//   done_o         one-cycle pulse at the end of a completed sweep
//   pass_o         truth_tbl_o == EXPECTED, valid from done_o until the next start
//   truth_tbl_o    captured table, bit k = y for vector k
//   err_cnt_o      failed-sweep count
module sop_sweep_ctrl
  import sop_ctrl_pkg::*;
#(
  parameter int                        NUM_VARS = 3,
  parameter int                        STEP_DIV = 1,
  parameter logic [(2**NUM_VARS)-1:0] EXPECTED = SOP_EXPECTED_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       y_i,
  output logic [NUM_VARS-1:0]        vec_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic [(2**NUM_VARS)-1:0]   truth_tbl_o,
  output logic [ERRCNT_W-1:0]        err_cnt_o
);

  localparam int TBL_W = 2**NUM_VARS;
  // One extra bit so the terminal-index compare never relies on wraparound.
  localparam int IDX_W = NUM_VARS + 1;
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(TBL_W - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(STEP_DIV - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TBL_W-1:0]  tbl_q, tbl_d;
  logic              pass_q, pass_d;

  logic tmr_clr, tmr_load, tmr_en, tmr_expire;

  sop_settle_timer #(.W(SETTLE_W)) u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .load_i    (tmr_load),
    .load_val_i(SETTLE_LOAD),
    .en_i      (tmr_en),
    .expire_o  (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tbl_d    = tbl_q;
    pass_d   = pass_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    vec_o    = '0;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          idx_d    = '0;
          tbl_d    = '0;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
          state_d  = APPLY;
        end
      end

      APPLY: begin
        busy_o = 1'b1;
        vec_o  = idx_q[NUM_VARS-1:0];
        if (abort_i) begin
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expire) begin
            state_d = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        busy_o = 1'b1;
        vec_o  = idx_q[NUM_VARS-1:0];
        if (abort_i) begin
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else begin
          tbl_d[idx_q[NUM_VARS-1:0]] = y_i;
          if (idx_q == LAST_IDX) begin
            // Judge on the next-value table so the final minterm is included
            // and pass_o is already valid while done_o is high.
            pass_d  = (tbl_d == EXPECTED);
            state_d = DONE;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
            state_d  = APPLY;
          end
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tbl_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      pass_q  <= pass_d;
    end
  end

  assign pass_o      = pass_q;
  assign truth_tbl_o = tbl_q;

`ifdef SOP_SWEEP_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  // Counts on the edge leaving DONE, where pass_q already holds the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if ((state_q == DONE) && !pass_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Self-checking bench for sop_sweep_ctrl: golden SOP model drives y_i, a queue holds the
// expected table/verdict of every started sweep and is drained when done_o appears.
// Edge counts include the edge that samples start_i as edge 1.
module tb_sop_sweep_ctrl;

`ifdef SOP_SWEEP_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  localparam logic [7:0] EXP_TBL = 8'h83;

  typedef struct {
    logic [7:0] tbl;
    logic       pass;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fault_en = 1'b0;

  logic       start1 = 1'b0, abort1 = 1'b0, y1;
  logic [2:0] vec1;
  logic       busy1, done1, pass1;
  logic [7:0] tbl1, err1;

  logic       start4 = 1'b0, abort4 = 1'b0, y4;
  logic [2:0] vec4;
  logic       busy4, done4, pass4;
  logic [7:0] tbl4, err4;

  always #5 clk = ~clk;

  function automatic logic golden(input logic [2:0] v);
    return (~v[2] & ~v[1] & ~v[0]) | (~v[2] & ~v[1] & v[0]) | (v[2] & v[1] & v[0]);
  endfunction

  function automatic logic [7:0] model_tbl(input bit fault);
    logic [7:0] t;
    for (int k = 0; k < 8; k++) begin
      t[k] = golden(3'(k)) & ~(fault && (k == 7));
    end
    return t;
  endfunction

  assign y1 = golden(vec1) & ~(fault_en && (vec1 == 3'd7));
  assign y4 = golden(vec4);

  sop_sweep_ctrl #(.NUM_VARS(3), .STEP_DIV(1), .EXPECTED(8'h83)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1), .y_i(y1),
    .vec_o(vec1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .truth_tbl_o(tbl1), .err_cnt_o(err1)
  );

  sop_sweep_ctrl #(.NUM_VARS(3), .STEP_DIV(4), .EXPECTED(8'h83)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .abort_i(abort4), .y_i(y4),
    .vec_o(vec4), .busy_o(busy4), .done_o(done4), .pass_o(pass4),
    .truth_tbl_o(tbl4), .err_cnt_o(err4)
  );

  // Runs one sweep from IDLE; returns the edge on which done_o was seen.
  task automatic do_sweep(input bit use4, input bit fault, input bit hold, output int edges);
    exp_t       e, got;
    int         walk_bad, step;
    logic [2:0] v;
    logic       b, d;
    step     = use4 ? 4 : 1;
    fault_en = fault;
    e.tbl    = model_tbl(fault);
    e.pass   = (e.tbl == EXP_TBL);
    exp_q.push_back(e);
    walk_bad = 0;
    edges    = 0;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    do begin
      @(posedge clk); #1;
      edges++;
      if (!hold) begin start1 = 1'b0; start4 = 1'b0; end
      d = use4 ? done4 : done1;
      b = use4 ? busy4 : busy1;
      v = use4 ? vec4 : vec1;
      if (d !== 1'b1) begin
        if (b !== 1'b1 || v !== 3'((edges - 1) / (step + 1))) walk_bad++;
      end
    end while (d !== 1'b1 && edges < 400);
    start1 = 1'b0;
    start4 = 1'b0;

    checks++;
    if (d !== 1'b1) begin
      errors++;
      $display("FAIL sweep_timeout: done_o not seen after %0d edges, required within 400", edges);
    end
    got = exp_q.pop_front();
    checks++;
    if ((use4 ? tbl4 : tbl1) !== got.tbl) begin
      errors++;
      $display("FAIL sweep_tbl: got %h required %h", (use4 ? tbl4 : tbl1), got.tbl);
    end
    checks++;
    if ((use4 ? pass4 : pass1) !== got.pass) begin
      errors++;
      $display("FAIL sweep_pass: got %b required %b", (use4 ? pass4 : pass1), got.pass);
    end
    checks++;
    if (walk_bad != 0) begin
      errors++;
      $display("FAIL vec_walk: %0d bad busy/vec samples, required 0", walk_bad);
    end
    @(posedge clk); #1;
    checks++;
    if ((use4 ? done4 : done1) !== 1'b0 || (use4 ? busy4 : busy1) !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b a cycle later, required 0 0",
               (use4 ? done4 : done1), (use4 ? busy4 : busy1));
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({vec1, busy1, done1, pass1, tbl1, err1} !== 22'd0) begin
      errors++;
      $display("FAIL reset_dut1: outputs %h required 0", {vec1, busy1, done1, pass1, tbl1, err1});
    end
    checks++;
    if ({vec4, busy4, done4, pass4, tbl4, err4} !== 22'd0) begin
      errors++;
      $display("FAIL reset_dut4: outputs %h required 0", {vec4, busy4, done4, pass4, tbl4, err4});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy1, done1);
    end
  endtask

  task automatic test_golden();
    int edges;
    do_sweep(1'b0, 1'b0, 1'b0, edges);
    checks++;
    if (edges != 17) begin
      errors++;
      $display("FAIL golden_latency: done on edge %0d required 17", edges);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pass1 !== 1'b1 || tbl1 !== EXP_TBL) begin
      errors++;
      $display("FAIL pass_hold: pass=%b tbl=%h required 1 83", pass1, tbl1);
    end
  endtask

  task automatic test_fault();
    int edges;
    do_sweep(1'b0, 1'b1, 1'b0, edges);
    checks++;
    if (tbl1 !== 8'h03 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL fault_tbl: tbl=%h pass=%b required 03 0", tbl1, pass1);
    end
    checks++;
    if (err1 !== (ERRCNT_ON ? 8'd1 : 8'd0)) begin
      errors++;
      $display("FAIL fault_errcnt: got %0d required %0d", err1, (ERRCNT_ON ? 1 : 0));
    end
    fault_en = 1'b0;
  endtask

  task automatic test_abort();
    int n, stray;
    logic [7:0] err_before;
    err_before = err1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 1;
    while (vec1 !== 3'd4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (vec1 !== 3'd4) begin
      errors++;
      $display("FAIL abort_reach: vec=%0d required 4", vec1);
    end
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || vec1 !== 3'd0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b vec=%0d done=%b required 0 0 0", busy1, vec1, done1);
    end
    checks++;
    if (tbl1 !== 8'h03 || pass1 !== 1'b0 || err1 !== err_before) begin
      errors++;
      $display("FAIL abort_state: tbl=%h pass=%b err=%0d required 03 0 %0d",
               tbl1, pass1, err1, err_before);
    end
    stray = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0 || busy1 !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d cycles active after abort, required 0", stray);
    end
  endtask

  task automatic test_start_hold();
    int edges, extra, busy_seen;
    do_sweep(1'b0, 1'b0, 1'b1, edges);
    checks++;
    if (edges != 17) begin
      errors++;
      $display("FAIL hold_latency: done on edge %0d required 17", edges);
    end
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL hold_single_done: %0d extra done pulses, required 0", extra);
    end
    start1    = 1'b1;
    abort1    = 1'b1;
    busy_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy1 !== 1'b0) busy_seen++;
    end
    start1 = 1'b0;
    abort1 = 1'b0;
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL start_abort_idle: busy on %0d cycles, required 0", busy_seen);
    end
  endtask

  task automatic test_async_reset();
    int edges;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec1, busy1, done1, pass1, tbl1, err1} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: outputs %h required 0", {vec1, busy1, done1, pass1, tbl1, err1});
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_sweep(1'b0, 1'b0, 1'b0, edges);
    checks++;
    if (edges != 17) begin
      errors++;
      $display("FAIL reset_resweep_latency: done on edge %0d required 17", edges);
    end
  endtask

  task automatic test_step4();
    int edges;
    do_sweep(1'b1, 1'b0, 1'b0, edges);
    checks++;
    if (edges != 41) begin
      errors++;
      $display("FAIL step4_latency: done on edge %0d required 41", edges);
    end
  endtask

  task automatic test_saturate();
    int edges;
    for (int i = 1; i <= 300; i++) begin
      do_sweep(1'b0, 1'b1, 1'b0, edges);
      if (i == 254) begin
        checks++;
        if (err1 !== (ERRCNT_ON ? 8'd254 : 8'd0)) begin
          errors++;
          $display("FAIL errcnt_254: got %0d required %0d", err1, (ERRCNT_ON ? 254 : 0));
        end
      end
    end
    checks++;
    if (err1 !== (ERRCNT_ON ? 8'd255 : 8'd0)) begin
      errors++;
      $display("FAIL errcnt_sat: got %0d required %0d", err1, (ERRCNT_ON ? 255 : 0));
    end
    fault_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_golden();
    test_fault();
    test_abort();
    test_start_hold();
    test_async_reset();
    test_step4();
    test_saturate();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
